// File: rtl/wave_pwm_dac_if.sv
// Sample stream from an upstream wave generator into the PWM DAC:
// valid/ready handshake carrying one unsigned WIDTH-bit sample.
interface wave_pwm_dac_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/wave_pwm_dac.sv
// 8-bit sample stream to single-bit PWM for an RC-filtered DAC pin; duty only changes at period boundaries.
// Define WAVE_PWM_SIGMA_DELTA_EN to replace the compare with a first-order sigma-delta modulator.
module wave_pwm_dac #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned WIDTH    = 8
) (
  input  logic           clk,
  input  logic           rst,
  wave_pwm_dac_if.slave  smp,
  output logic           pwm_out,
  output logic           period_start,
  output logic           underrun
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    presc_cnt;
  logic [WIDTH-1:0] ph_cnt;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             tick;
  logic             boundary;
  logic             accept;

  always_comb begin
    tick     = (presc_cnt == PRESC_LAST);
    boundary = tick && (ph_cnt == '1);
    accept   = smp.sample_valid && !hold_full;
  end

  assign smp.sample_ready = ~hold_full;

  // Prescaler and phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      ph_cnt    <= '0;
    end else begin
      if (tick) begin
        presc_cnt <= '0;
        ph_cnt    <= ph_cnt + WIDTH'(1);
      end else begin
        presc_cnt <= presc_cnt + PW'(1);
      end
    end
  end

  // Holding buffer; a boundary drains it, otherwise an empty buffer may fill
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      duty      <= '0;
    end else if (boundary && hold_full) begin
      duty      <= hold;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= smp.sample_in;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      period_start <= boundary;
      underrun     <= boundary && !hold_full;
    end
  end

`ifdef WAVE_PWM_SIGMA_DELTA_EN
  // Accumulator carry spreads the duty's ones evenly over the period
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, duty};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      pwm_out <= 1'b0;
    end else if (tick) begin
      acc     <= acc_sum[WIDTH-1:0];
      pwm_out <= acc_sum[WIDTH];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) pwm_out <= 1'b0;
    else     pwm_out <= (ph_cnt < duty);
  end
`endif

endmodule
